// File: rtl/csh_pkg.sv
// rtl/csh_pkg.sv - shared state encoding and default sizing for the cache request sequencer
package csh_pkg;

  localparam int CSH_LINE_WORDS = 4;
  localparam int CSH_TIMEOUT    = 255;

  typedef enum logic [2:0] {
    IDLE,
    T0,
    RETRY,
    MISS,
    FILL,
    WREQ,
    WWAIT,
    RESP
  } cshState_t;

endpackage

// File: rtl/csh_req_seq_if.sv
// rtl/csh_req_seq_if.sv - MCL/EBOX request and memory handshake bundle for csh_req_seq
interface csh_req_seq_if import csh_pkg::*; #(
  parameter int LINE_WORDS = CSH_LINE_WORDS
);

  localparam int WC_W = $clog2(LINE_WORDS);

  logic            eboxReqIn;
  logic            reqWrite;
  logic            cacheHit;
  logic            pfEBOXHandle;
  logic            memAck;
  logic            memDone;
  logic            cshEBOXT0;
  logic            cshEBOXRetry;
  logic            mboxRespIn;
  logic            memReq;
  logic            memWrite;
  logic            cshWrEn;
  logic [WC_W-1:0] wordCnt;
  logic            nxm;
  logic            busy;

  // The sequencer is the slave: it answers EBOX requests and the memory handshake.
  modport slave (
    input  eboxReqIn, reqWrite, cacheHit, pfEBOXHandle, memAck, memDone,
    output cshEBOXT0, cshEBOXRetry, mboxRespIn, memReq, memWrite, cshWrEn,
           wordCnt, nxm, busy
  );

  modport master (
    output eboxReqIn, reqWrite, cacheHit, pfEBOXHandle, memAck, memDone,
    input  cshEBOXT0, cshEBOXRetry, mboxRespIn, memReq, memWrite, cshWrEn,
           wordCnt, nxm, busy
  );

endinterface

// File: rtl/csh_timeout.sv
// rtl/csh_timeout.sv - memory-response watchdog counting idle cycles while a transfer is outstanding
module csh_timeout import csh_pkg::*; #(
  parameter int TIMEOUT = CSH_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  input  logic clr,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] idleCnt;

  always_ff @(posedge clk) begin
    if (reset || !run || clr) begin
      idleCnt <= '0;
    end else begin
      idleCnt <= idleCnt + 1'b1;
    end
  end

  // Fires on the TIMEOUT-th consecutive idle cycle so the FSM leaves on that edge.
  assign expired = run && !clr && (idleCnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/csh_req_seq.sv
// rtl/csh_req_seq.sv - cache request sequencer: T0 lookup, page-fail retry, line refill, write-through, NXM watchdog
module csh_req_seq import csh_pkg::*; #(
  parameter int LINE_WORDS = CSH_LINE_WORDS,
  parameter int TIMEOUT    = CSH_TIMEOUT
) (
  input logic          clk,
  input logic          reset,
  csh_req_seq_if.slave bus
);

  localparam int              WC_W      = $clog2(LINE_WORDS);
  localparam logic [WC_W-1:0] LAST_WORD = WC_W'(LINE_WORDS - 1);

  cshState_t       state;
  logic            hitQ;
  logic            wdRun;
  logic            wdClr;
  logic            expired;
  logic            t0Q;
  logic            retryQ;
  logic            respQ;
  logic            memReqQ;
  logic            memWriteQ;
  logic            wrEnQ;
  logic            nxmQ;
  logic            busyQ;
  logic [WC_W-1:0] wordCntQ;

  assign wdRun = state inside {MISS, FILL, WREQ, WWAIT};
  // Only the handshake that is meaningful in the current state counts as progress.
  assign wdClr = ((state == MISS || state == WREQ) && bus.memAck) ||
                 ((state == FILL || state == WWAIT) && bus.memDone);

  csh_timeout #(.TIMEOUT(TIMEOUT)) uWatchdog (
    .clk     (clk),
    .reset   (reset),
    .run     (wdRun),
    .clr     (wdClr),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      hitQ      <= 1'b0;
      t0Q       <= 1'b0;
      retryQ    <= 1'b0;
      respQ     <= 1'b0;
      memReqQ   <= 1'b0;
      memWriteQ <= 1'b0;
      wrEnQ     <= 1'b0;
      nxmQ      <= 1'b0;
      busyQ     <= 1'b0;
      wordCntQ  <= '0;
    end else begin
      t0Q    <= 1'b0;
      retryQ <= 1'b0;
      respQ  <= 1'b0;
      wrEnQ  <= 1'b0;
      nxmQ   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.eboxReqIn) begin
            state <= T0;
            t0Q   <= 1'b1;
            busyQ <= 1'b1;
          end
        end
        T0: begin
          hitQ <= bus.cacheHit;
          if (bus.pfEBOXHandle) begin
            state  <= RETRY;
            retryQ <= 1'b1;
          end else if (bus.reqWrite) begin
            state     <= WREQ;
            memReqQ   <= 1'b1;
            memWriteQ <= 1'b1;
          end else if (bus.cacheHit) begin
            state <= RESP;
            respQ <= 1'b1;
          end else begin
            state   <= MISS;
            memReqQ <= 1'b1;
          end
        end
        RETRY, RESP: begin
          state <= IDLE;
          busyQ <= 1'b0;
        end
        MISS, WREQ: begin
          // A memDone arriving with memAck here is deliberately not consumed.
          if (bus.memAck) begin
            state     <= (state == MISS) ? FILL : WWAIT;
            memReqQ   <= 1'b0;
            memWriteQ <= 1'b0;
            wordCntQ  <= '0;
          end
        end
        FILL: begin
          if (bus.memDone) begin
            wrEnQ    <= 1'b1;
            wordCntQ <= wordCntQ + 1'b1;
            if (wordCntQ == LAST_WORD) begin
              state <= RESP;
              respQ <= 1'b1;
            end
          end
        end
        WWAIT: begin
          if (bus.memDone) begin
            wrEnQ <= hitQ;
            state <= RESP;
            respQ <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
      if (expired) begin
        state     <= RESP;
        respQ     <= 1'b1;
        nxmQ      <= 1'b1;
        memReqQ   <= 1'b0;
        memWriteQ <= 1'b0;
      end
    end
  end

  assign bus.cshEBOXT0    = t0Q;
  assign bus.cshEBOXRetry = retryQ;
  assign bus.mboxRespIn   = respQ;
  assign bus.memReq       = memReqQ;
  assign bus.memWrite     = memWriteQ;
  assign bus.cshWrEn      = wrEnQ;
  assign bus.wordCnt      = wordCntQ;
  assign bus.nxm          = nxmQ;
  assign bus.busy         = busyQ;

endmodule
